// File: rtl/serial_twos_negator_pkg.sv
// rtl/serial_twos_negator_pkg.sv - shared FSM state encoding for the serial two's-complement negator
//
// Purpose: FSM state constants shared by the negator top and its bench-facing documentation.
//   S_IDLE  = 2'd0  waiting for start, ready=1
//   S_SHIFT = 2'd1  one operand bit per cycle, LSB first
//   S_DONE  = 2'd2  single-cycle result-complete state
package serial_twos_negator_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/serial_twos_negator_bit_cell.sv
// rtl/serial_twos_negator_bit_cell.sv - copy-until-first-1-then-invert cell for serial negation
//
// Purpose: one bit slice of -A = ~A + 1 evaluated LSB first. Bits up to and including the first 1
//   pass unchanged; every later bit is inverted. The seen_one flag stands in for the +1 carry chain.
// Ports:
//   b           in   current operand bit
//   seen_one_q  in   a 1 has already passed through the cell in this operation
//   out         out  negated result bit
//   seen_one_d  out  updated flag for the next bit
module negate_bit_cell (
  input  logic b,
  input  logic seen_one_q,
  output logic out,
  output logic seen_one_d
);

  logic b_n;
  logic seen_n;

  // Inverters are NANDs with both inputs tied together.
  assign b_n    = ~(b & b);
  assign seen_n = ~(seen_one_q & seen_one_q);

  // Select inverted bit once a 1 has been seen, original bit before that.
  assign out        = (seen_one_q & b_n) | (seen_n & b);
  assign seen_one_d = seen_one_q | b;

endmodule

// File: rtl/serial_twos_negator.sv
// rtl/serial_twos_negator.sv - bit-serial two's-complement negator with reassembled parallel result
//
// Purpose: accepts a WIDTH-bit operand, streams -a LSB first on sout/sout_valid over WIDTH cycles,
//   then presents the assembled result on neg_a with a one-cycle done pulse.
// Ports:
//   clk         in   clock, all state on posedge
//   rst         in   synchronous active-high reset
//   start       in   load a and begin (accepted only while ready)
//   a           in   operand, sampled on the accepting edge
//   ready       out  idle, can accept start
//   busy        out  shifting
//   sout        out  current negated bit, LSB first
//   sout_valid  out  sout carries a result bit
//   neg_a       out  assembled -a, stable from done until the next accepted start
//   done        out  one-cycle result-complete pulse
//   ovf         out  operand was the most-negative value (result wraps to itself)
module serial_twos_negator
  import serial_twos_negator_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  output logic             ready,
  output logic             busy,
  output logic             sout,
  output logic             sout_valid,
  output logic [WIDTH-1:0] neg_a,
  output logic             done,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] neg_q, neg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             seen_q, seen_d;
  logic             ovf_q, ovf_d;

  logic             cell_out;
  logic             cell_seen;

  negate_bit_cell u_cell (
    .b          (sr_q[0]),
    .seen_one_q (seen_q),
    .out        (cell_out),
    .seen_one_d (cell_seen)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      neg_q   <= '0;
      cnt_q   <= '0;
      seen_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      neg_q   <= neg_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SHIFT;
      S_SHIFT: if (cnt_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    sr_d   = sr_q;
    neg_d  = neg_q;
    cnt_d  = cnt_q;
    seen_d = seen_q;
    ovf_d  = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          sr_d   = a;
          cnt_d  = '0;
          seen_d = 1'b0;
          ovf_d  = (a == MOST_NEG);
        end
      end
      S_SHIFT: begin
        // Result fills from the MSB end so the LSB lands at bit 0 after WIDTH shifts.
        neg_d  = {cell_out, neg_q[WIDTH-1:1]};
        sr_d   = sr_q >> 1;
        seen_d = cell_seen;
        cnt_d  = cnt_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    ready      = (state_q == S_IDLE);
    busy       = (state_q == S_SHIFT);
    sout_valid = (state_q == S_SHIFT);
    sout       = (state_q == S_SHIFT) ? cell_out : 1'b0;
    done       = (state_q == S_DONE);
    neg_a      = neg_q;
    ovf        = ovf_q;
  end

endmodule

// File: tb/tb_serial_twos_negator.sv
// tb/tb_serial_twos_negator.sv - self-checking bench for serial_twos_negator
module tb_serial_twos_negator;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic         ready;
  logic         busy;
  logic         sout;
  logic         sout_valid;
  logic [W-1:0] neg_a;
  logic         done;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  serial_twos_negator #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .a          (a),
    .ready      (ready),
    .busy       (busy),
    .sout       (sout),
    .sout_valid (sout_valid),
    .neg_a      (neg_a),
    .done       (done),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference: interpret a as signed, negate, wrap modulo 2^W.
  function automatic int as_signed(input logic [W-1:0] av);
    int m;
    m = 1 << W;
    return (int'(av) >= m / 2) ? int'(av) - m : int'(av);
  endfunction

  function automatic logic [W-1:0] ref_neg(input logic [W-1:0] av);
    int m;
    m = 1 << W;
    return W'((((-as_signed(av)) % m) + m) % m);
  endfunction

  function automatic bit ref_ovf(input logic [W-1:0] av);
    return (-as_signed(av)) > ((1 << (W - 1)) - 1);
  endfunction

  // Called mid-IDLE cycle; returns mid-IDLE cycle with start low.
  task automatic do_op(input logic [W-1:0] av, input bit noise);
    logic [W-1:0] e;
    bit           o;
    e = ref_neg(av);
    o = ref_ovf(av);
    start = 1'b1;
    a     = av;
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      if (k <= W) begin
        check("sout", sout, e[k-1]);
        check("sout_valid", sout_valid, 1);
        check("busy", busy, 1);
        check("ready_shift", ready, 0);
        check("done_early", done, 0);
      end else if (k == W + 1) begin
        check("done", done, 1);
        check("neg_a", neg_a, e);
        check("ovf", ovf, o);
        check("busy_done", busy, 0);
        check("ready_done", ready, 0);
      end else begin
        check("ready_after", ready, 1);
        check("done_once", done, 0);
        check("neg_a_hold", neg_a, e);
        check("ovf_hold", ovf, o);
      end
      if (noise && k <= W + 1) begin
        start = 1'($urandom_range(0, 1));
        a     = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int d1;
    int d2;
    int ndone;
    logic [W-1:0] last;

    rst   = 1'b1;
    start = 1'b1;
    a     = 4'b1000;
    repeat (2) @(negedge clk);
    check("rst_ready", ready, 1);
    check("rst_busy", busy, 0);
    check("rst_sout", sout, 0);
    check("rst_sout_valid", sout_valid, 0);
    check("rst_neg_a", neg_a, 0);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    rst   = 1'b0;
    start = 1'b0;

    // Directed cases.
    do_op(4'b0011, 1'b0);
    do_op(4'b0000, 1'b0);
    do_op(4'b0001, 1'b0);
    do_op(4'b1000, 1'b0);
    do_op(4'b0110, 1'b0);

    // Start pulse while busy must be ignored.
    start = 1'b1;
    a     = 4'b0101;
    @(negedge clk);
    start = 1'b1;
    a     = 4'b0010;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    for (int k = 3; k <= 12; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        check("ign_neg_a", neg_a, 4'b1011);
        check("ign_ovf", ovf, 0);
      end
    end
    check("ign_done_count", ndone, 1);

    // Reset mid-SHIFT.
    do_op(4'b1000, 1'b0);
    start = 1'b1;
    a     = 4'b0111;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", ready, 1);
    check("mrst_busy", busy, 0);
    check("mrst_neg_a", neg_a, 0);
    check("mrst_ovf", ovf, 0);
    check("mrst_sout_valid", sout_valid, 0);
    ndone = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("mrst_no_done", ndone, 0);

    // Back-to-back with start held high.
    d1    = -1;
    d2    = -1;
    start = 1'b1;
    a     = 4'b0001;
    for (int cyc = 1; cyc <= 13; cyc++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = cyc;
          check("b2b_neg_a1", neg_a, 4'b1111);
        end else begin
          d2 = cyc;
          check("b2b_neg_a2", neg_a, 4'b1100);
        end
      end
      if (cyc == 5) a = 4'b0100;
      if (cyc == 11) start = 1'b0;
    end
    check("b2b_done1_cycle", d1, 5);
    check("b2b_done2_cycle", d2, 11);

    // Randomized operations with idle gaps and ignored start noise.
    last = 4'b1100;
    for (int n = 0; n < 40; n++) begin
      int gap;
      logic [W-1:0] av;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        @(negedge clk);
        check("gap_ready", ready, 1);
        check("gap_neg_a", neg_a, last);
      end
      av = W'($urandom);
      do_op(av, 1'($urandom_range(0, 1)));
      last = ref_neg(av);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
